// File: rtl/current_scheduler_if.sv
// current_scheduler_if: step control, spike events, neuron-current handoff and current-store ports
interface current_scheduler_if #(
  parameter int DATA_W = 17,
  parameter int TAG_W  = 1
);
  logic              step_start;
  logic              step_done;
  logic              busy;
  logic              ev_valid;
  logic [TAG_W-1:0]  ev_tag;
  logic [DATA_W-1:0] ev_weight;
  logic              ev_ready;
  logic              ev_flush;
  logic              nu_valid;
  logic              nu_ready;
  logic [TAG_W-1:0]  nu_tag;
  logic [DATA_W-1:0] nu_current;
  logic              swap;
  logic              i_next_write_en;
  logic [TAG_W-1:0]  i_next_write_tag;
  logic [DATA_W-1:0] i_next_write_value;
  logic [TAG_W-1:0]  i_next_read_tag;
  logic [DATA_W-1:0] i_next_read_value;
  logic [TAG_W-1:0]  i_read_tag;
  logic [DATA_W-1:0] i_read_value;
  modport master (
    input  step_start, ev_valid, ev_tag, ev_weight, ev_flush, nu_ready,
           i_next_read_value, i_read_value,
    output step_done, busy, ev_ready, nu_valid, nu_tag, nu_current, swap,
           i_next_write_en, i_next_write_tag, i_next_write_value, i_next_read_tag, i_read_tag
  );
  modport slave (
    output step_start, ev_valid, ev_tag, ev_weight, ev_flush, nu_ready,
           i_next_read_value, i_read_value,
    input  step_done, busy, ev_ready, nu_valid, nu_tag, nu_current, swap,
           i_next_write_en, i_next_write_tag, i_next_write_value, i_next_read_tag, i_read_tag
  );
endinterface

// File: rtl/current_scheduler.sv
// current_scheduler: accumulates spike weights into the next-step buffer, sweeps currents out, swaps and clears
module current_scheduler #(
  parameter int DATA_W    = 17,
  parameter int TAG_W     = 1,
  parameter int N_NEURONS = 2
) (
  input logic               clk,
  input logic               asyn_reset,
  current_scheduler_if.master bus
);
  typedef enum logic [2:0] {IDLE, SWEEP, WAIT_EV, SWAP, CLEAR, DONE} state_t;
  localparam logic [TAG_W-1:0]  LAST  = TAG_W'(N_NEURONS - 1);
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  state_t            state_q, state_d;
  logic [TAG_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [DATA_W-1:0] s1_weight_q, s1_weight_d;
  logic              ev_window;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sat;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ev_window = state_q == SWEEP || state_q == WAIT_EV;
    flush_d = flush_q | (ev_window & bus.ev_flush);
    bus.ev_ready = ev_window & ~flush_q;
    s1_valid_d = bus.ev_valid & bus.ev_ready;
    s1_tag_d = s1_valid_d ? bus.ev_tag : '0;
    s1_weight_d = s1_valid_d ? bus.ev_weight : '0;
    // widen by one bit so overflow shows up as a sign mismatch
    sum = {bus.i_next_read_value[DATA_W-1], bus.i_next_read_value} + {s1_weight_q[DATA_W-1], s1_weight_q};
    sat = (sum[DATA_W] != sum[DATA_W-1]) ? (sum[DATA_W] ? S_MIN : S_MAX) : sum[DATA_W-1:0];
    bus.busy = state_q != IDLE;
    bus.nu_valid = state_q == SWEEP;
    bus.nu_tag = bus.nu_valid ? cnt_q : '0;
    bus.i_read_tag = bus.nu_valid ? cnt_q : '0;
    bus.nu_current = bus.nu_valid ? bus.i_read_value : '0;
    bus.swap = state_q == SWAP;
    bus.step_done = state_q == DONE;
    bus.i_next_read_tag = s1_valid_q ? s1_tag_q : '0;
    bus.i_next_write_en = s1_valid_q || state_q == CLEAR;
    bus.i_next_write_tag = state_q == CLEAR ? cnt_q : bus.i_next_read_tag;
    bus.i_next_write_value = s1_valid_q ? sat : '0;
    case (state_q)
      IDLE: if (bus.step_start) begin
        cnt_d = '0;
        flush_d = 1'b0;
        state_d = SWEEP;
      end
      SWEEP: if (bus.nu_ready) begin
        state_d = cnt_q == LAST ? WAIT_EV : SWEEP;
        cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
      end
      WAIT_EV: state_d = (flush_q && !s1_valid_q) ? SWAP : WAIT_EV;
      SWAP: begin
        cnt_d = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        state_d = cnt_q == LAST ? DONE : CLEAR;
        cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      flush_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_tag_q <= '0;
      s1_weight_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      flush_q <= flush_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q <= s1_tag_d;
      s1_weight_q <= s1_weight_d;
    end
  end
endmodule

// File: doc/current_scheduler.md
# current_scheduler

Timestep controller for the double-buffered synaptic current store (`current_update`). It accumulates incoming spike-event weights into the next-step buffer with a read-modify-write and a saturating add. It sweeps the current-step buffer and hands each neuron's input current to the neuron update engine, then issues `swap` and clears the recycled buffer. It sits between the spike router (event source), the neuron update engine (current consumer) and one `current_update` instance.

## Interface
- `DATA_W`, 17: current/weight width, signed two's complement.
- `TAG_W`, 1: neuron tag width.
- `N_NEURONS`, 2: neurons swept per timestep; must satisfy 1 ≤ N_NEURONS ≤ 2^TAG_W.

Ports:
- `clk` in 1: clock, rising-edge.
- `asyn_reset` in 1: reset, synchronous, active-high.
- `step_start` in 1: one-cycle pulse that begins a timestep; ignored unless IDLE.
- `step_done` out 1: one-cycle pulse when the timestep completes.
- `busy` out 1: high whenever state ≠ IDLE.
- `ev_valid` in 1: spike event valid.
- `ev_tag` in TAG_W: target neuron of the event.
- `ev_weight` in DATA_W: signed weight of the event.
- `ev_ready` out 1: event accepted when `ev_valid & ev_ready` at a rising edge.
- `ev_flush` in 1: pulse meaning no more events this timestep.
- `nu_valid` out 1: a current is offered to the neuron engine.
- `nu_ready` in 1: the neuron engine accepts the offered current.
- `nu_tag` out TAG_W: neuron tag being offered.
- `nu_current` out DATA_W: current being offered.
- `swap` out 1: drives `current_update.swap`.
- `i_next_write_en` out 1: drives the store's next-buffer write enable.
- `i_next_write_tag` out TAG_W: next-buffer write tag.
- `i_next_write_value` out DATA_W: next-buffer write value.
- `i_next_read_tag` out TAG_W: next-buffer read tag.
- `i_next_read_value` in DATA_W: next-buffer read data.
- `i_read_tag` out TAG_W: current-buffer read tag.
- `i_read_value` in DATA_W: current-buffer read data.

## Operation
- **Store behaviour.** Store reads are combinational. Writes and `swap` take effect at the rising edge.
- **State machine.** States are IDLE, SWEEP, WAIT_EV, SWAP, CLEAR and DONE. A TAG_W counter `cnt` steps through neurons.
- **IDLE.** On `step_start`: clear `cnt` and `flush_seen`, then go to SWEEP.
- **SWEEP.**
  - Outputs: `nu_valid`=1, `nu_tag`=`i_read_tag`=`cnt`, `nu_current`=`i_read_value` (combinational).
  - On a handshake with `cnt`=N_NEURONS-1, go to WAIT_EV; otherwise increment `cnt`.
- **WAIT_EV.** When `flush_seen & !s1_valid`, go to SWAP.
- **SWAP.** Assert `swap` for exactly 1 cycle, clear `cnt`, go to CLEAR.
- **CLEAR.**
  - Drive `i_next_write_en`=1, `i_next_write_tag`=`cnt`, `i_next_write_value`=0.
  - At `cnt`=N_NEURONS-1 go to DONE; otherwise increment `cnt`.
- **DONE.** Assert `step_done` for 1 cycle, then go to IDLE.
- **Flush tracking.** `flush_seen` sets on `ev_flush` in SWEEP or WAIT_EV. `ev_flush` in any other state is ignored.
- **Event acceptance.** `ev_ready` = (SWEEP or WAIT_EV) & !`flush_seen`. An event accepted in the same cycle that `ev_flush` arrives belongs to this timestep.
- **Event pipeline, stage 1.** An accepted event is registered as `s1_valid`/`s1_tag`/`s1_weight`.
- **Event pipeline, stage 2.** Runs in the cycle after acceptance:
  - `i_next_read_tag`=`s1_tag` and `i_next_write_tag`=`s1_tag`.
  - `i_next_write_value`=sat(`i_next_read_value` + `s1_weight`).
  - `i_next_write_en`=1.
  - Throughput is 1 event/cycle. Back-to-back events to the same tag are hazard-free because the read is combinational after the prior edge's write.
- **Saturation.** The sum is computed at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. For DATA_W=17 that is 0x10000..0x0FFFF.
- **Write-port ownership.** The event pipeline is empty before SWAP, so event writes and CLEAR writes never coincide.
- **Idle output values.** Unused tag and value outputs are 0. `i_next_write_en`=0 when no write is active.
- **Reset.** `asyn_reset` from any state, mid-operation included, takes effect at the next edge:
  - state → IDLE; `cnt`, `flush_seen` and `s1_valid` are cleared; a pending event is dropped.
  - All outputs are 0, including `ev_ready`, `nu_valid`, `swap`, `step_done` and `busy`.

## Timing
- **Timestep sequence.** Let `step_start` be sampled at edge k, with no backpressure and `ev_flush` already seen:
  - SWEEP in cycles k+1..k+N.
  - WAIT_EV in cycle k+N+1.
  - SWAP in cycle k+N+2.
  - CLEAR in cycles k+N+3..k+2N+2.
  - `step_done` in cycle k+2N+3.
- **Sweep handshake.** `nu_valid`, `nu_tag` and `nu_current` hold stable while `nu_ready` is low. Each stalled cycle delays `step_done` by one cycle.
- **Event write latency.** An event accepted at edge e is written at edge e+1.
- **Late flush.** WAIT_EV persists until `ev_flush` arrives, plus one drain cycle if stage 1 is valid.
- **`swap`.** Never high for more than 1 cycle. Never high while `s1_valid` is set.

## Test plan
- **Reset.** Hold `asyn_reset` 2 cycles mid-SWEEP → next cycle all outputs 0, `busy`=0; `swap` never asserts.
- **Basic step.** Step 1: events tag0 +0x08000 and tag1 +0x04000, then flush, with `nu_ready`=1.
  - Step 2 sweep → `nu_current` 0x08000 (tag0) and 0x04000 (tag1).
  - Step 3 sweep → 0x00000 for both tags (buffer cleared).
- **Same-tag back-to-back.** Three consecutive-cycle events to tag0 of +0x01000 → next step's tag0 current = 0x03000.
- **Saturation.**
  - Tag1 +0x0C000 twice → 0x0FFFF.
  - Tag0 with 0x14000 (−0x0C000) twice → 0x10000.
- **Backpressure.** `nu_ready`=0 for 3 cycles at tag0 → `nu_valid`/`nu_tag`/`nu_current` stable; `step_done` at k+2N+6 (vs k+2N+3).
- **Flush edge cases.**
  - `ev_flush` together with an accepted event → the event is counted in this step; `ev_ready`=0 from the next cycle.
  - `ev_flush` while IDLE → ignored.
